// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing, index type and age helper for the reservation-station issue scheduler.
package rs_pkg;

    localparam int RS_SIZE = 64;
    localparam int IDX_W   = 6;
    localparam int NUM_ALU = 3;

    typedef logic [IDX_W-1:0] rs_idx_t;

    // Distance from the RS head, wrapping modulo RS_SIZE; zero is the oldest entry.
    function automatic rs_idx_t age_of(rs_idx_t idx, rs_idx_t head);
        return rs_idx_t'(idx - head);
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Scheduler <-> RS / functional-unit signal bundle; master is the scheduler side.
interface rs_issue_scheduler_if;
    import rs_pkg::*;

    logic                     flush;
    rs_idx_t                  rs_head;
    logic [RS_SIZE-1:0]       ent_valid;
    logic [RS_SIZE-1:0]       ent_ready;
    logic [RS_SIZE-1:0]       ent_is_mem;
    logic [NUM_ALU-1:0]       alu_grant_valid;
    logic [NUM_ALU*IDX_W-1:0] alu_grant_idx;
    logic [NUM_ALU-1:0]       alu_fu_ready;
    logic                     ls_grant_valid;
    rs_idx_t                  ls_grant_idx;
    logic                     ls_fu_ready;
    logic [RS_SIZE-1:0]       issue_clear;
    logic                     hold_compact;

    modport master (
        input  flush, rs_head, ent_valid, ent_ready, ent_is_mem,
        input  alu_fu_ready, ls_fu_ready,
        output alu_grant_valid, alu_grant_idx, ls_grant_valid, ls_grant_idx,
        output issue_clear, hold_compact
    );

    modport slave (
        output flush, rs_head, ent_valid, ent_ready, ent_is_mem,
        output alu_fu_ready, ls_fu_ready,
        input  alu_grant_valid, alu_grant_idx, ls_grant_valid, ls_grant_idx,
        input  issue_clear, hold_compact
    );

endinterface

// File: rtl/rs_issue_scheduler_age_pick_oldest.sv
// Combinational search for the request bit with the smallest age relative to a head index.
module age_pick_oldest
    import rs_pkg::*;
(
    input  logic [RS_SIZE-1:0] i_req,
    input  rs_idx_t            i_head,
    output logic               o_found,
    output rs_idx_t            o_idx
);

    rs_idx_t w_best_age;

    always_comb begin
        o_found    = 1'b0;
        o_idx      = i_head;
        w_best_age = '1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (i_req[i] && (!o_found || age_of(rs_idx_t'(i), i_head) < w_best_age)) begin
                o_found    = 1'b1;
                o_idx      = rs_idx_t'(i);
                w_best_age = age_of(rs_idx_t'(i), i_head);
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler: NUM_ALU ALU grant slots plus one in-order LSU slot, each
// held under valid/ready until accepted, with slot-clear and compaction-freeze outputs.
module rs_issue_scheduler
    import rs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rs_issue_scheduler_if.master  io_sch
);

    localparam int FILL_W = $clog2(NUM_ALU + 1);

    logic [NUM_ALU-1:0] r_alu_vld;
    rs_idx_t            r_alu_idx [NUM_ALU];
    logic               r_ls_vld;
    rs_idx_t            r_ls_idx;

    logic [NUM_ALU-1:0] w_alu_vld_nxt;
    rs_idx_t            w_alu_idx_nxt [NUM_ALU];
    logic               w_ls_vld_nxt;
    rs_idx_t            w_ls_idx_nxt;

    logic [RS_SIZE-1:0] w_pending;
    logic [RS_SIZE-1:0] w_alu_req [NUM_ALU];
    logic [NUM_ALU-1:0] w_pick_found;
    rs_idx_t            w_pick_idx [NUM_ALU];
    logic               w_ls_found;
    rs_idx_t            w_ls_oldest;
    logic               w_ls_eligible;
    logic [NUM_ALU-1:0] w_alu_acc;
    logic               w_ls_acc;
    logic [FILL_W-1:0]  w_fill;
    logic [RS_SIZE-1:0] w_clear;

    assign w_alu_acc = r_alu_vld & io_sch.alu_fu_ready;
    assign w_ls_acc  = r_ls_vld & io_sch.ls_fu_ready;

    // Indices already sitting in a grant register, accepted this cycle or not, stay
    // off the candidate list so the same entry can never be issued twice.
    always_comb begin
        w_pending = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (r_alu_vld[k]) w_pending[r_alu_idx[k]] = 1'b1;
        end
        if (r_ls_vld) w_pending[r_ls_idx] = 1'b1;
    end

    assign w_alu_req[0] = io_sch.ent_valid & io_sch.ent_ready & ~io_sch.ent_is_mem & ~w_pending;

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu_pick
        age_pick_oldest u_pick (
            .i_req   (w_alu_req[k]),
            .i_head  (io_sch.rs_head),
            .o_found (w_pick_found[k]),
            .o_idx   (w_pick_idx[k])
        );
        if (k < NUM_ALU - 1) begin : g_mask
            assign w_alu_req[k+1] = w_alu_req[k] & ~(RS_SIZE'(w_pick_found[k]) << w_pick_idx[k]);
        end
    end

    // The LSU only ever looks at the oldest occupied memory entry, ready or not.
    age_pick_oldest u_ls_pick (
        .i_req   (io_sch.ent_valid & io_sch.ent_is_mem),
        .i_head  (io_sch.rs_head),
        .o_found (w_ls_found),
        .o_idx   (w_ls_oldest)
    );

    assign w_ls_eligible = w_ls_found && io_sch.ent_ready[w_ls_oldest] && !w_pending[w_ls_oldest];

    always_comb begin
        w_alu_vld_nxt = r_alu_vld;
        w_alu_idx_nxt = r_alu_idx;
        w_ls_vld_nxt  = r_ls_vld;
        w_ls_idx_nxt  = r_ls_idx;
        w_fill        = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (!r_alu_vld[k] || w_alu_acc[k]) begin
                if (w_pick_found[w_fill]) begin
                    w_alu_vld_nxt[k] = 1'b1;
                    w_alu_idx_nxt[k] = w_pick_idx[w_fill];
                    w_fill           = w_fill + FILL_W'(1);
                end else begin
                    w_alu_vld_nxt[k] = 1'b0;
                end
            end
        end
        if (!r_ls_vld || w_ls_acc) begin
            w_ls_vld_nxt = w_ls_eligible;
            if (w_ls_eligible) w_ls_idx_nxt = w_ls_oldest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_vld <= '0;
            r_ls_vld  <= 1'b0;
            r_ls_idx  <= '0;
            for (int k = 0; k < NUM_ALU; k++) r_alu_idx[k] <= '0;
        end else if (io_sch.flush) begin
            r_alu_vld <= '0;
            r_ls_vld  <= 1'b0;
        end else begin
            r_alu_vld <= w_alu_vld_nxt;
            r_ls_vld  <= w_ls_vld_nxt;
            r_ls_idx  <= w_ls_idx_nxt;
            for (int k = 0; k < NUM_ALU; k++) r_alu_idx[k] <= w_alu_idx_nxt[k];
        end
    end

    // Accepts still clear their slots during a flush; reset discards them silently.
    always_comb begin
        w_clear = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_ALU; k++) begin
                if (w_alu_acc[k]) w_clear[r_alu_idx[k]] = 1'b1;
            end
            if (w_ls_acc) w_clear[r_ls_idx] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_idx_out
        assign io_sch.alu_grant_idx[k*IDX_W +: IDX_W] = r_alu_idx[k];
    end

    assign io_sch.alu_grant_valid = r_alu_vld;
    assign io_sch.ls_grant_valid  = r_ls_vld;
    assign io_sch.ls_grant_idx    = r_ls_idx;
    assign io_sch.issue_clear     = w_clear;
    assign io_sch.hold_compact    = |r_alu_vld | r_ls_vld;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed scenarios plus random traffic against a queue-based age-order reference model.
module tb_rs_issue_scheduler;

    logic clk;
    logic rst;

    rs_issue_scheduler_if ifc();

    rs_issue_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .io_sch (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side RS image and FU stimulus
    bit [63:0] rv, rr, rm;
    bit [5:0]  head;
    bit [2:0]  frdy;
    bit        lrdy;
    bit        fl;

    // Reference grant state
    bit        m_av [3];
    bit [5:0]  m_ai [3];
    bit        m_lv;
    bit [5:0]  m_li;

    bit [63:0] obs_clear;
    int        n_chk;
    int        n_fail;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit held(int i);
        for (int k = 0; k < 3; k++) if (m_av[k] && m_ai[k] == i) return 1'b1;
        return m_lv && m_li == i;
    endfunction

    function automatic bit any_held();
        return m_av[0] || m_av[1] || m_av[2] || m_lv;
    endfunction

    function automatic bit [63:0] exp_clear();
        bit [63:0] c;
        c = '0;
        if (rst) return c;
        for (int k = 0; k < 3; k++) if (m_av[k] && frdy[k]) c[m_ai[k]] = 1'b1;
        if (m_lv && lrdy) c[m_li] = 1'b1;
        return c;
    endfunction

    // Next grant state from the scheduling rules, evaluated on pre-edge inputs.
    task automatic model_step();
        int  q[$];
        int  oldest;
        bit  free_slot;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin m_av[k] = 0; m_ai[k] = 0; end
            m_lv = 0; m_li = 0;
            return;
        end
        if (fl) begin
            for (int k = 0; k < 3; k++) m_av[k] = 0;
            m_lv = 0;
            return;
        end
        for (int a = 0; a < 64; a++) begin
            int i = (int'(head) + a) % 64;
            if (rv[i] && rr[i] && !rm[i] && !held(i)) q.push_back(i);
        end
        oldest = -1;
        for (int a = 0; a < 64; a++) begin
            int i = (int'(head) + a) % 64;
            if (rv[i] && rm[i]) begin oldest = i; break; end
        end
        if (!m_lv || lrdy) begin
            if (oldest >= 0 && rr[oldest] && !held(oldest)) begin
                m_lv = 1; m_li = 6'(oldest);
            end else begin
                m_lv = 0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            free_slot = !m_av[k] || frdy[k];
            if (free_slot) begin
                if (q.size() > 0) begin
                    m_av[k] = 1; m_ai[k] = 6'(q.pop_front());
                end else begin
                    m_av[k] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        bit [63:0] c;
        ifc.flush        = fl;
        ifc.rs_head      = head;
        ifc.ent_valid    = rv;
        ifc.ent_ready    = rr;
        ifc.ent_is_mem   = rm;
        ifc.alu_fu_ready = frdy;
        ifc.ls_fu_ready  = lrdy;
        @(negedge clk);
        c = exp_clear();
        obs_clear = ifc.issue_clear;
        chk("alu_valid", ifc.alu_grant_valid, {m_av[2], m_av[1], m_av[0]});
        for (int k = 0; k < 3; k++)
            if (m_av[k]) chk($sformatf("alu%0d_idx", k), ifc.alu_grant_idx[k*6 +: 6], m_ai[k]);
        chk("ls_valid", ifc.ls_grant_valid, m_lv);
        if (m_lv) chk("ls_idx", ifc.ls_grant_idx, m_li);
        chk("issue_clear", ifc.issue_clear, c);
        chk("hold_compact", ifc.hold_compact, any_held());
        @(posedge clk);
        model_step();
        rv &= ~c;
        #1;
    endtask

    task automatic set_ent(int i, bit ready, bit mem);
        rv[i] = 1; rr[i] = ready; rm[i] = mem;
    endtask

    int ncyc;
    int pop;
    int idx_i;

    initial begin
        rst = 1; fl = 0; frdy = 0; lrdy = 0; head = 0;
        rv = '1; rr = '1; rm = '1;
        n_chk = 0; n_fail = 0;

        // Reset with every entry occupied and ready
        cycle(); cycle();
        chk("rst_alu_idx", ifc.alu_grant_idx, 18'd0);
        chk("rst_ls_valid", ifc.ls_grant_valid, 0);
        rst = 0;
        cycle();
        chk("rst_first_ls_valid", ifc.ls_grant_valid, 1);
        chk("rst_first_ls_idx", ifc.ls_grant_idx, 0);
        rst = 1; rv = '0; rr = '0; rm = '0;
        cycle();
        rst = 0;
        cycle();

        // Age order across the wrap point
        head = 62;
        set_ent(5, 1, 0); set_ent(63, 1, 0); set_ent(62, 1, 0); set_ent(1, 1, 0);
        cycle();
        chk("wrap_idx", ifc.alu_grant_idx, {6'd1, 6'd63, 6'd62});
        repeat (3) begin
            cycle();
            chk("wrap_hold", ifc.hold_compact, 1);
            chk("wrap_hold_idx", ifc.alu_grant_idx, {6'd1, 6'd63, 6'd62});
        end
        frdy = 3'b010;
        cycle();
        chk("b2b_clear", obs_clear, 64'h8000_0000_0000_0000);
        chk("b2b_idx", ifc.alu_grant_idx, {6'd1, 6'd5, 6'd62});
        frdy = 3'b111;
        for (int t = 0; t < 6 && rv != 0; t++) cycle();
        frdy = 0;
        cycle();
        chk("wrap_idle", ifc.hold_compact, 0);

        // LSU strict ordering
        head = 0;
        set_ent(10, 0, 1); set_ent(12, 1, 1);
        cycle(); cycle();
        chk("ls_blocked", ifc.ls_grant_valid, 0);
        rr[10] = 1;
        cycle();
        chk("ls_first_idx", ifc.ls_grant_idx, 10);
        lrdy = 1;
        cycle();
        chk("ls_clear10", obs_clear, 64'h400);
        lrdy = 0;
        cycle();
        chk("ls_second_valid", ifc.ls_grant_valid, 1);
        chk("ls_second_idx", ifc.ls_grant_idx, 12);
        lrdy = 1;
        cycle();
        lrdy = 0;
        cycle();

        // Flush with a simultaneous accept
        for (int i = 20; i < 24; i++) set_ent(i, 1, 0);
        cycle();
        fl = 1; frdy = 3'b001;
        cycle();
        chk("flush_clear", obs_clear, 64'h10_0000);
        chk("flush_drop", ifc.alu_grant_valid, 0);
        fl = 0; frdy = 0;
        cycle();
        chk("flush_regrant", ifc.alu_grant_idx, {6'd23, 6'd22, 6'd21});
        frdy = 3'b111;
        for (int t = 0; t < 6 && rv != 0; t++) cycle();
        frdy = 0;
        cycle();

        // Saturation: full RS, none ready, then all ready at once
        head = 17; rv = '1; rr = '0; rm = '0;
        repeat (3) cycle();
        chk("sat_nogrant", ifc.hold_compact, 0);
        rr = '1; frdy = 3'b111;
        ncyc = 0; pop = 0;
        for (int t = 0; t < 40 && rv != 0; t++) begin
            cycle();
            if (obs_clear != 0) ncyc++;
            pop += $countones(obs_clear);
        end
        chk("sat_cycles", ncyc, 22);
        chk("sat_total", pop, 64);
        frdy = 0;
        cycle();

        // Random traffic
        for (int t = 0; t < 3000; t++) begin
            rst  = ($urandom_range(0, 199) == 0);
            fl   = ($urandom_range(0, 49) == 0);
            frdy = 3'($urandom);
            lrdy = 1'($urandom);
            repeat (3) begin
                idx_i = $urandom_range(0, 63);
                if (!rv[idx_i]) set_ent(idx_i, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            end
            repeat (2) begin
                idx_i = $urandom_range(0, 63);
                if (rv[idx_i]) rr[idx_i] = 1;
            end
            if (!any_held() && $urandom_range(0, 9) == 0) head = 6'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
